dw2_11_gen: RTL and testbench

// - Writer side of the w2_11 weight register: computes dw2_11 = -(ETA * delta2_1 * a1_1), all signed Q8.24.
// - Drives the register's select_initial / select_update strobes.
// - Sits between the output-layer error stage and the w2_11 register.
// - One multiply unit, used twice in sequence; result issued with a 1-cycle update strobe.

---
 rtl/dw2_11_gen_pkg.sv | 21 ++
 rtl/dw2_11_gen_mul.sv | 85 ++++++++
 rtl/dw2_11_gen.sv | 118 +++++++++++
 tb/tb_dw2_11_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dw2_11_gen_pkg.sv
// Shared fixed-point constants and FSM state type for the w2_11 weight-delta
// writer. Q8.24 format: 32-bit signed, 24 fractional bits.
package dw2_11_gen_pkg;

  localparam int Q_DATA_W = 32;
  localparam int Q_FRAC_W = 24;

  localparam logic [31:0] SAT_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN     = 32'h8000_0000;
  localparam logic [31:0] ETA_DEFAULT = 32'h0080_0000;  // 0.5
  localparam logic [31:0] W2_11_INIT  = 32'h0019_9999;  // ~0.1

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_MUL1,
    ST_MUL2,
    ST_ISSUE
  } state_t;

endpackage

// File: rtl/dw2_11_gen_mul.sv
// mul_q8_24_seq: radix-2 shift-add signed fixed-point multiplier.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   go           load a/b and perform the first partial-product step
//   a, b         signed operands (DATA_W bits, FRAC_W fractional)
//   done         1-cycle pulse: p holds the finished product this cycle
//   p            product truncated to DATA_W bits (floor) and saturated
// The go edge consumes b[0]; DATA_W-1 further edges consume the remaining
// bits, so done is high exactly DATA_W cycles after go. A go while running
// restarts the multiply.
module mul_q8_24_seq
  import dw2_11_gen_pkg::*;
#(
  parameter int DATA_W = Q_DATA_W,
  parameter int FRAC_W = Q_FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] p
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int HI_W   = DATA_W - FRAC_W + 1;

  localparam logic [DATA_W-1:0] P_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] P_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [PROD_W-1:0] acc;
  logic signed [PROD_W-1:0] mcand;
  logic        [DATA_W-1:0] mplier;
  logic        [CNT_W-1:0]  remaining;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] partial;
  logic        [HI_W-1:0]   hi;
  logic                     unused_low;

  assign a_ext   = {{DATA_W{a[DATA_W-1]}}, a};
  assign partial = mplier[0] ? mcand : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else if (go) begin
      acc       <= b[0] ? a_ext : '0;
      mcand     <= a_ext << 1;
      mplier    <= b >> 1;
      remaining <= CNT_W'(DATA_W - 1);
      done      <= 1'b0;
    end else if (remaining != '0) begin
      // Last step carries the two's-complement sign weight of b: subtract.
      if (remaining == CNT_W'(1))
        acc <= acc - partial;
      else
        acc <= acc + partial;
      mcand     <= mcand << 1;
      mplier    <= mplier >> 1;
      remaining <= remaining - CNT_W'(1);
      done      <= (remaining == CNT_W'(1));
    end else begin
      done <= 1'b0;
    end
  end

  // Discarded high bits plus the result sign bit must all agree, otherwise
  // the truncated value does not fit and is clamped.
  assign hi = acc[PROD_W-1 -: HI_W];

  always_comb begin
    p = acc[FRAC_W+DATA_W-1 : FRAC_W];
    if (!(hi == '0 || hi == '1))
      p = acc[PROD_W-1] ? P_MIN : P_MAX;
  end

  assign unused_low = ^acc[FRAC_W-1:0];

endmodule

// File: rtl/dw2_11_gen.sv
// dw2_11_gen: writer side of the w2_11 weight register.
// Computes dw2_11 = -(ETA * delta2_1 * a1_1) in signed Q8.24 with one shared
// sequential multiplier used twice, then issues a 1-cycle update strobe.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   init            request weight initialisation (select_initial strobe)
//   start           request one update computation
//   delta2_1, a1_1  signed operands, captured on an accepted start
//   busy            high from the cycle after accepted start to the strobe
//   dw2_11          weight delta, held between updates
//   select_initial  1-cycle strobe: register loads its initial value
//   select_update   1-cycle strobe: register adds dw2_11
module dw2_11_gen
  import dw2_11_gen_pkg::*;
#(
  parameter int                DATA_W = Q_DATA_W,
  parameter int                FRAC_W = Q_FRAC_W,
  parameter logic [DATA_W-1:0] ETA    = DATA_W'(ETA_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              start,
  input  logic [DATA_W-1:0] delta2_1,
  input  logic [DATA_W-1:0] a1_1,
  output logic              busy,
  output logic [DATA_W-1:0] dw2_11,
  output logic              select_initial,
  output logic              select_update
);

  localparam logic [DATA_W-1:0] NEG_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state;
  logic              kick;
  logic [DATA_W-1:0] op_delta;
  logic [DATA_W-1:0] op_a1;
  logic              mul_go;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic              mul_done;
  logic [DATA_W-1:0] mul_p;

  function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] x);
    return (x == NEG_MIN) ? NEG_MAX : (~x + DATA_W'(1));
  endfunction

  // The second multiply starts on the same edge the first one finishes,
  // feeding the live product straight back as an operand so both passes fit
  // back-to-back without an idle cycle.
  always_comb begin
    mul_go = kick || (state == ST_MUL1 && mul_done);
    mul_a  = kick ? ETA      : mul_p;
    mul_b  = kick ? op_delta : op_a1;
  end

  mul_q8_24_seq #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .go    (mul_go),
    .a     (mul_a),
    .b     (mul_b),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      dw2_11         <= '0;
      select_initial <= 1'b0;
      select_update  <= 1'b0;
      kick           <= 1'b0;
      op_delta       <= '0;
      op_a1          <= '0;
    end else begin
      kick           <= 1'b0;
      select_initial <= 1'b0;
      select_update  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (init) begin
            state          <= ST_INIT;
            select_initial <= 1'b1;
          end else if (start) begin
            state    <= ST_MUL1;
            op_delta <= delta2_1;
            op_a1    <= a1_1;
            kick     <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_INIT: state <= ST_IDLE;
        ST_MUL1: begin
          if (mul_done) state <= ST_MUL2;
        end
        ST_MUL2: begin
          if (mul_done) begin
            state         <= ST_ISSUE;
            dw2_11        <= sat_neg(mul_p);
            select_update <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dw2_11_gen.sv
module tb_dw2_11_gen;
  import dw2_11_gen_pkg::*;

  localparam logic [31:0] ETA0 = 32'h0080_0000;
  localparam logic [31:0] ETA1 = 32'h7FFF_FFFF;

  typedef struct {
    logic [31:0] dw;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init = 1'b0;
  logic        start = 1'b0;
  logic [31:0] delta2_1 = '0;
  logic [31:0] a1_1 = '0;

  logic        busy0, sel_init0, upd0;
  logic [31:0] dw0;
  logic        busy1, sel_init1, upd1;
  logic [31:0] dw1;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] weight = '0;

  dw2_11_gen dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .start          (start),
    .delta2_1       (delta2_1),
    .a1_1           (a1_1),
    .busy           (busy0),
    .dw2_11         (dw0),
    .select_initial (sel_init0),
    .select_update  (upd0)
  );

  dw2_11_gen #(.ETA(ETA1)) dut_sat (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .start          (start),
    .delta2_1       (delta2_1),
    .a1_1           (a1_1),
    .busy           (busy1),
    .dw2_11         (dw1),
    .select_initial (sel_init1),
    .select_update  (upd1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mulq(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb, pr;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    pr = (pa * pb) >>> 24;
    if (pr > 64'sh7FFF_FFFF) return SAT_MAX;
    if (pr < -64'sh8000_0000) return SAT_MIN;
    return pr[31:0];
  endfunction

  function automatic logic [31:0] negsat(input logic [31:0] x);
    return (x == SAT_MIN) ? SAT_MAX : -x;
  endfunction

  // Scoreboard for the default-ETA instance, plus a behavioural w2_11 register.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() == 0) begin
      check("no_spurious_upd0", {31'b0, upd0}, 32'd0);
    end else if (upd0) begin
      e = q0.pop_front();
      check("dw0", dw0, e.dw);
      check("latency0", cyc, e.due);
      check("busy_at_strobe0", {31'b0, busy0}, 32'd1);
      check("strobe_excl0", {31'b0, sel_init0}, 32'd0);
    end
    if (sel_init0) weight = W2_11_INIT;
    else if (upd0) weight = weight + dw0;
  end

  // Scoreboard for the ETA=max instance.
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() == 0) begin
      check("no_spurious_upd1", {31'b0, upd1}, 32'd0);
    end else if (upd1) begin
      e = q1.pop_front();
      check("dw1", dw1, e.dw);
      check("latency1", cyc, e.due);
    end
  end

  task automatic run_op(input logic [31:0] d, input logic [31:0] a);
    delta2_1 = d;
    a1_1     = a;
    start    = 1'b1;
    q0.push_back('{dw: negsat(mulq(mulq(ETA0, d), a)), due: cyc + 66});
    q1.push_back('{dw: negsat(mulq(mulq(ETA1, d), a)), due: cyc + 66});
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'b0, busy0}, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++)
      @(negedge clk);
    check("drain_q0", q0.size(), 32'd0);
    check("drain_q1", q1.size(), 32'd0);
    @(negedge clk);
    check("busy_clear", {31'b0, busy0}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy0}, 32'd0);
    check("rst_dw", dw0, 32'd0);
    check("rst_sel_init", {31'b0, sel_init0}, 32'd0);
    check("rst_sel_upd", {31'b0, upd0}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Init pulse: one select_initial cycle, nothing else moves.
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("init_strobe", {31'b0, sel_init0}, 32'd1);
    check("init_dw", dw0, 32'd0);
    check("init_busy", {31'b0, busy0}, 32'd0);
    @(negedge clk);
    check("init_strobe_off", {31'b0, sel_init0}, 32'd0);

    // 1.0 x 0.5 with ETA 0.5 -> -0.25.
    run_op(32'h0100_0000, 32'h0080_0000);
    wait_drain();
    check("dw_hold", dw0, 32'hFFC0_0000);

    // Saturating cases.
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_drain();
    check("sat_pos", dw1, 32'h8000_0001);
    run_op(32'h8000_0000, 32'h7FFF_FFFF);
    wait_drain();
    check("sat_neg", dw1, 32'h7FFF_FFFF);

    // init and start together: init wins, start dropped.
    delta2_1 = 32'h0100_0000;
    a1_1     = 32'h0100_0000;
    init     = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    init  = 1'b0;
    start = 1'b0;
    check("both_sel_init", {31'b0, sel_init0}, 32'd1);
    check("both_busy", {31'b0, busy0}, 32'd0);
    @(negedge clk);
    check("both_busy_later", {31'b0, busy0}, 32'd0);

    // start/init while busy are ignored: exactly one update.
    run_op(32'hFF00_0000, 32'h0200_0000);
    repeat (9) @(negedge clk);
    delta2_1 = 32'h0300_0000;
    a1_1     = 32'h0300_0000;
    start    = 1'b1;
    init     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    init  = 1'b0;
    check("busy_init_ignored", {31'b0, sel_init0}, 32'd0);
    wait_drain();
    repeat (80) @(negedge clk);

    // Reset during the second multiply aborts without a strobe.
    delta2_1 = 32'h0100_0000;
    a1_1     = 32'h0100_0000;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, busy0}, 32'd0);
    check("abort_dw", dw0, 32'd0);
    check("abort_sel_init", {31'b0, sel_init0}, 32'd0);
    check("abort_sel_upd", {31'b0, upd0}, 32'd0);
    repeat (80) @(negedge clk);

    // Closed loop with the w2_11 register.
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    check("weight_init", weight, W2_11_INIT);
    run_op(32'hFFB3_3334, 32'h0100_0000);
    wait_drain();
    check("weight_updated", weight,
          W2_11_INIT + negsat(mulq(mulq(ETA0, 32'hFFB3_3334), 32'h0100_0000)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
